// File: rtl/obi_ascon_mgr_arb.sv
// Round-robin arbiter sharing one OBI manager port among the ASCON DMA managers.
// An in-order ID FIFO routes each response back to the requester that issued it.
module obi_ascon_mgr_arb #(
    parameter int unsigned NumReq    = 5,
    parameter int unsigned MaxOutst  = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AidWidth  = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             testmode_i,
    input  logic [NumReq-1:0]                req_i_req,
    input  logic [NumReq*AddrWidth-1:0]      req_i_addr,
    input  logic [NumReq-1:0]                req_i_we,
    input  logic [NumReq*(DataWidth/8)-1:0]  req_i_be,
    input  logic [NumReq*DataWidth-1:0]      req_i_wdata,
    input  logic [NumReq*AidWidth-1:0]       req_i_aid,
    output logic [NumReq-1:0]                rsp_o_gnt,
    output logic [NumReq-1:0]                rsp_o_rvalid,
    output logic [NumReq*DataWidth-1:0]      rsp_o_rdata,
    output logic [NumReq*AidWidth-1:0]       rsp_o_rid,
    output logic [NumReq-1:0]                rsp_o_err,
    output logic                             req_o_req,
    output logic [AddrWidth-1:0]             req_o_addr,
    output logic                             req_o_we,
    output logic [DataWidth/8-1:0]           req_o_be,
    output logic [DataWidth-1:0]             req_o_wdata,
    output logic [AidWidth-1:0]              req_o_aid,
    input  logic                             rsp_i_gnt,
    input  logic                             rsp_i_rvalid,
    input  logic [DataWidth-1:0]             rsp_i_rdata,
    input  logic [AidWidth-1:0]              rsp_i_rid,
    input  logic                             rsp_i_err,
    output logic [$clog2(MaxOutst):0]        outst_o,
    output logic                             err_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = $clog2(MaxOutst);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BeW  = DataWidth / 8;
    localparam logic [IdxW:0]   NumReqL = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutst);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] sel_q, sel_d;
    logic [IdxW-1:0] rr_sel;
    logic            rr_found;
    logic [IdxW:0]   cand;
    logic [IdxW-1:0] sel;

    logic [IdxW-1:0] fifo_mem [MaxOutst];
    logic [PtrW-1:0] wptr, rptr;
    logic [CntW-1:0] cnt;
    logic [IdxW-1:0] head;
    logic            full, empty;
    logic            handshake, pop;
    logic            err_q;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // Search starts one past the last winner and wraps modulo NumReq.
    always_comb begin
        rr_sel   = ptr;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            cand = {1'b0, ptr} + i[IdxW:0];
            if (cand >= NumReqL) begin
                cand = cand - NumReqL;
            end
            if (!rr_found && req_i_req[cand[IdxW-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = cand[IdxW-1:0];
            end
        end
    end

    assign sel = (state_q == ST_LOCKED) ? sel_q : rr_sel;

    assign full  = (cnt == FullCnt);
    assign empty = (cnt == '0);
    assign head  = fifo_mem[rptr];

    // full and empty come from the count register only, so rvalid never reaches req or gnt.
    assign req_o_req   = req_i_req[sel] && !full && !rst_i;
    assign req_o_addr  = req_i_addr[sel*AddrWidth +: AddrWidth];
    assign req_o_we    = req_i_we[sel];
    assign req_o_be    = req_i_be[sel*BeW +: BeW];
    assign req_o_wdata = req_i_wdata[sel*DataWidth +: DataWidth];
    assign req_o_aid   = req_i_aid[sel*AidWidth +: AidWidth];

    assign handshake = req_o_req && rsp_i_gnt;
    assign pop       = rsp_i_rvalid && !empty;

    always_comb begin
        rsp_o_gnt      = '0;
        rsp_o_gnt[sel] = handshake;
    end

    always_comb begin
        rsp_o_rvalid       = '0;
        rsp_o_rvalid[head] = pop;
    end

    assign rsp_o_rdata = {NumReq{rsp_i_rdata}};
    assign rsp_o_rid   = {NumReq{rsp_i_rid}};
    assign rsp_o_err   = {NumReq{rsp_i_err}};

    // Hold the selection while a request waits for its grant.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_FREE: begin
                if (req_o_req && !rsp_i_gnt) begin
                    state_d = ST_LOCKED;
                    sel_d   = sel;
                end
            end
            ST_LOCKED: begin
                if (!req_o_req || rsp_i_gnt) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FREE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= LastIdx;
        end else if (handshake) begin
            ptr <= sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MaxOutst; i++) begin
                fifo_mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (handshake) begin
                fifo_mem[wptr] <= sel;
                wptr           <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({handshake, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (rsp_i_rvalid && empty) begin
            err_q <= 1'b1;
        end
    end

    assign outst_o = cnt;
    assign err_o   = err_q;

endmodule

// File: tb/tb_obi_ascon_mgr_arb.sv
// Randomized and directed bench for obi_ascon_mgr_arb against a queue-based model
// of round-robin arbitration, grant locking and in-order response routing.
module tb_obi_ascon_mgr_arb;

    localparam int NR = 5;
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;

    logic                clk_i;
    logic                rst_i;
    logic                testmode_i;
    logic [NR-1:0]       req_i_req;
    logic [NR*AW-1:0]    req_i_addr;
    logic [NR-1:0]       req_i_we;
    logic [NR*4-1:0]     req_i_be;
    logic [NR*DW-1:0]    req_i_wdata;
    logic [NR*IW-1:0]    req_i_aid;
    logic [NR-1:0]       rsp_o_gnt;
    logic [NR-1:0]       rsp_o_rvalid;
    logic [NR*DW-1:0]    rsp_o_rdata;
    logic [NR*IW-1:0]    rsp_o_rid;
    logic [NR-1:0]       rsp_o_err;
    logic                req_o_req;
    logic [AW-1:0]       req_o_addr;
    logic                req_o_we;
    logic [3:0]          req_o_be;
    logic [DW-1:0]       req_o_wdata;
    logic [IW-1:0]       req_o_aid;
    logic                rsp_i_gnt;
    logic                rsp_i_rvalid;
    logic [DW-1:0]       rsp_i_rdata;
    logic [IW-1:0]       rsp_i_rid;
    logic                rsp_i_err;
    logic [2:0]          outst_o;
    logic                err_o;

    obi_ascon_mgr_arb #(
        .NumReq   (NR),
        .MaxOutst (MO),
        .AddrWidth(AW),
        .DataWidth(DW),
        .AidWidth (IW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .testmode_i  (testmode_i),
        .req_i_req   (req_i_req),
        .req_i_addr  (req_i_addr),
        .req_i_we    (req_i_we),
        .req_i_be    (req_i_be),
        .req_i_wdata (req_i_wdata),
        .req_i_aid   (req_i_aid),
        .rsp_o_gnt   (rsp_o_gnt),
        .rsp_o_rvalid(rsp_o_rvalid),
        .rsp_o_rdata (rsp_o_rdata),
        .rsp_o_rid   (rsp_o_rid),
        .rsp_o_err   (rsp_o_err),
        .req_o_req   (req_o_req),
        .req_o_addr  (req_o_addr),
        .req_o_we    (req_o_we),
        .req_o_be    (req_o_be),
        .req_o_wdata (req_o_wdata),
        .req_o_aid   (req_o_aid),
        .rsp_i_gnt   (rsp_i_gnt),
        .rsp_i_rvalid(rsp_i_rvalid),
        .rsp_i_rdata (rsp_i_rdata),
        .rsp_i_rid   (rsp_i_rid),
        .rsp_i_err   (rsp_i_err),
        .outst_o     (outst_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // requester-side stimulus state
    bit          r_req   [NR];
    logic [31:0] r_addr  [NR];
    logic [31:0] r_wdata [NR];
    logic        r_we    [NR];
    logic [3:0]  r_be    [NR];
    logic        r_aid   [NR];
    int          req_prob;
    int          rsp_pct;
    bit          auto_rsp;
    bit          t_gnt;
    bit          t_rvalid;
    logic [31:0] t_rdata;

    // reference model state
    int q[$];
    int m_ptr;
    bit m_locked;
    int m_sel;
    bit m_err;
    bit in_rst;

    int seen[$];
    int n_pass;
    int n_checks;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void new_payload(int k);
        r_addr[k]  = $urandom;
        r_wdata[k] = $urandom;
        r_we[k]    = 1'($urandom_range(0, 1));
        r_be[k]    = 4'($urandom);
        r_aid[k]   = 1'($urandom);
    endfunction

    task automatic drive();
        if (auto_rsp) begin
            t_rvalid = (q.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
            t_rdata  = $urandom;
        end
        for (int k = 0; k < NR; k++) begin
            req_i_req[k]           = r_req[k];
            req_i_addr[k*AW +: AW] = r_addr[k];
            req_i_we[k]            = r_we[k];
            req_i_be[k*4 +: 4]     = r_be[k];
            req_i_wdata[k*DW +: DW] = r_wdata[k];
            req_i_aid[k*IW +: IW]  = r_aid[k];
        end
        rsp_i_gnt    = t_gnt;
        rsp_i_rvalid = t_rvalid;
        rsp_i_rdata  = t_rdata;
        rsp_i_rid    = 1'($urandom);
        rsp_i_err    = 1'($urandom);
    endtask

    function automatic int model_sel();
        if (m_locked) return m_sel;
        for (int i = 1; i <= NR; i++) begin
            int c;
            c = (m_ptr + i) % NR;
            if (r_req[c]) return c;
        end
        return -1;
    endfunction

    // Compare one cycle at the falling edge, then advance the model to the next rising edge.
    task automatic do_cycle();
        int s;
        bit full, empty, ereq;
        logic [NR-1:0] egnt, erv;
        @(negedge clk_i);
        s     = model_sel();
        full  = (q.size() == MO);
        empty = (q.size() == 0);
        ereq  = !in_rst && (s >= 0) && r_req[s] && !full;
        egnt  = '0;
        if (ereq && t_gnt) egnt[s] = 1'b1;
        erv = '0;
        if (!in_rst && t_rvalid && !empty) erv[q[0]] = 1'b1;
        check("req", req_o_req, ereq);
        if (ereq) begin
            check("addr", req_o_addr, r_addr[s]);
            check("wdata", req_o_wdata, r_wdata[s]);
            check("we", req_o_we, r_we[s]);
            check("be", req_o_be, r_be[s]);
            check("aid", req_o_aid, r_aid[s]);
        end
        check("gnt", rsp_o_gnt, egnt);
        check("rvalid", rsp_o_rvalid, erv);
        check("rdata", rsp_o_rdata, {NR{t_rdata}});
        check("rid", rsp_o_rid, {NR{rsp_i_rid}});
        check("rerr", rsp_o_err, {NR{rsp_i_err}});
        check("outst", outst_o, q.size());
        check("err", err_o, m_err);
        for (int k = 0; k < NR; k++) if (rsp_o_gnt[k]) seen.push_back(k);
        if (!in_rst) begin
            if (t_rvalid) begin
                if (empty) m_err = 1'b1;
                else void'(q.pop_front());
            end
            if (ereq && t_gnt) begin
                q.push_back(s);
                m_ptr    = s;
                m_locked = 1'b0;
                if ($urandom_range(0, 99) < req_prob) begin
                    r_req[s] = 1'b1;
                    new_payload(s);
                end else begin
                    r_req[s] = 1'b0;
                end
            end else if (ereq) begin
                m_locked = 1'b1;
                m_sel    = s;
            end else begin
                m_locked = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        q.delete();
        m_ptr    = NR - 1;
        m_locked = 1'b0;
        m_err    = 1'b0;
        in_rst   = 1'b1;
        do_cycle();
        rst_i  = 1'b0;
        in_rst = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NR; k++) r_req[k] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_a[4];
        int exp_b[10];
        int cnt_b[NR];
        logic [NR-1:0] route_rv[3];
        logic [31:0]   route_d[3];
        int            route_k[3];
        int            exp_c[3];

        n_pass = 0; n_checks = 0;
        testmode_i = 1'b0;
        rst_i = 1'b1;
        auto_rsp = 1'b1; rsp_pct = 100; req_prob = 100;
        t_gnt = 1'b1; t_rvalid = 1'b0; t_rdata = '0;
        for (int k = 0; k < NR; k++) begin
            r_req[k] = 1'b0;
            new_payload(k);
        end

        // reset gating, then 0/3 alternation
        r_req[0] = 1'b1;
        drive();
        do_reset();
        r_req[3] = 1'b1;
        seen.delete();
        repeat (4) begin drive(); do_cycle(); end
        exp_a = '{0, 3, 0, 3};
        check("rst_order_len", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check("rst_order", seen[i], exp_a[i]);

        // fairness with all five requesting
        clear_reqs(); t_gnt = 1'b0;
        repeat (6) begin drive(); do_cycle(); end
        for (int k = 0; k < NR; k++) begin r_req[k] = 1'b1; new_payload(k); end
        drive();
        do_reset();
        t_gnt = 1'b1;
        seen.delete();
        repeat (10) begin drive(); do_cycle(); end
        exp_b = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        check("fair_len", seen.size(), 10);
        for (int k = 0; k < NR; k++) cnt_b[k] = 0;
        for (int i = 0; i < 10 && i < seen.size(); i++) begin
            check("fair_order", seen[i], exp_b[i]);
            cnt_b[seen[i]]++;
        end
        for (int k = 0; k < NR; k++) check("fair_count", cnt_b[k], 2);

        // lock: index 2 waits for grant while index 0 rises
        clear_reqs(); t_gnt = 1'b0;
        drive();
        do_reset();
        req_prob = 0;
        r_req[2] = 1'b1; new_payload(2); r_addr[2] = 32'h1000_0008;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin r_req[0] = 1'b1; new_payload(0); end
            t_gnt = (c == 3);
            drive(); #1;
            check("lock_addr", req_o_addr, 32'h1000_0008);
            if (c == 3) check("lock_gnt", rsp_o_gnt, 5'b00100);
            do_cycle();
        end
        drive(); #1;
        check("lock_next", rsp_o_gnt, 5'b00001);
        do_cycle();

        // full: four grants with no responses
        clear_reqs();
        drive();
        do_reset();
        auto_rsp = 1'b0; t_rvalid = 1'b0; t_gnt = 1'b1; req_prob = 100;
        r_req[0] = 1'b1; new_payload(0);
        repeat (4) begin drive(); do_cycle(); end
        drive(); #1;
        check("full_outst", outst_o, 4);
        check("full_req", req_o_req, 1'b0);
        do_cycle();
        t_rvalid = 1'b1; t_rdata = $urandom;
        drive(); #1;
        check("full_req_pop", req_o_req, 1'b0);
        do_cycle();
        t_rvalid = 1'b0;
        drive(); #1;
        check("pop_outst", outst_o, 3);
        check("pop_gnt", rsp_o_gnt, 5'b00001);
        do_cycle();

        // routing: grants 4, 1, 4 then responses A, B, C
        clear_reqs(); t_gnt = 1'b0; auto_rsp = 1'b1; rsp_pct = 100;
        repeat (6) begin drive(); do_cycle(); end
        auto_rsp = 1'b0; t_rvalid = 1'b0; req_prob = 0; t_gnt = 1'b1;
        seen.delete();
        r_req[4] = 1'b1; new_payload(4); drive(); do_cycle();
        r_req[1] = 1'b1; new_payload(1); drive(); do_cycle();
        r_req[4] = 1'b1; new_payload(4); drive(); do_cycle();
        exp_c = '{4, 1, 4};
        check("route_len", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) check("route_order", seen[i], exp_c[i]);
        t_gnt = 1'b0;
        route_rv = '{5'b10000, 5'b00010, 5'b10000};
        route_d  = '{32'hA, 32'hB, 32'hC};
        route_k  = '{4, 1, 4};
        for (int i = 0; i < 3; i++) begin
            t_rvalid = 1'b1; t_rdata = route_d[i];
            drive(); #1;
            check("route_rv", rsp_o_rvalid, route_rv[i]);
            check("route_data", rsp_o_rdata[route_k[i]*DW +: DW], route_d[i]);
            do_cycle();
        end
        t_rvalid = 1'b0;

        // error after mid-operation reset
        drive();
        do_reset();
        r_req[0] = 1'b1; new_payload(0); req_prob = 100; t_gnt = 1'b1;
        repeat (2) begin drive(); do_cycle(); end
        clear_reqs(); t_gnt = 1'b0;
        drive(); #1;
        check("err_outst", outst_o, 2);
        do_cycle();
        drive();
        do_reset();
        t_rvalid = 1'b1; t_rdata = $urandom;
        drive(); #1;
        check("err_rv", rsp_o_rvalid, 5'b00000);
        do_cycle();
        t_rvalid = 1'b0;
        drive(); #1;
        check("err_set", err_o, 1'b1);
        repeat (5) begin drive(); do_cycle(); end
        check("err_sticky", err_o, 1'b1);

        // randomized traffic
        drive();
        do_reset();
        auto_rsp = 1'b1; rsp_pct = 60; req_prob = 50;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NR; k++) begin
                if (!r_req[k] && $urandom_range(0, 99) < 25) begin
                    r_req[k] = 1'b1;
                    new_payload(k);
                end
            end
            t_gnt = ($urandom_range(0, 99) < 70);
            drive();
            if (n == 1500) do_reset();
            else do_cycle();
        end

        drive();
        do_reset();
        check("final_outst", outst_o, 0);
        check("final_err", err_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/obi_ascon_mgr_arb.md
# obi_ascon_mgr_arb

Round-robin arbiter that shares one OBI manager port into the Croc crossbar among the DMA managers of the ASCON accelerator: auth write, bdo write, cmd read, key read and bdi read. It sits between the DMA engines' `mgr_req_o`/`mgr_rsp_i` vector and a single user-domain manager port, so the accelerator uses one crossbar manager slot instead of five. It tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.

## Interface
- `NumReq`, 5: number of requesting DMA managers; requester index = vector position.
- `MaxOutst`, 4: maximum outstanding (granted, not yet responded) transactions; power of two, at least 2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, reset is asynchronous and active-high.
- `testmode_i`  in  1  unused; reserved for DFT.
- `req_i`  in  `mgr_obi_req_t [NumReq-1:0]`  requests from the DMA managers.
- `rsp_o`  out  `mgr_obi_rsp_t [NumReq-1:0]`  responses to the DMA managers.
- `req_o`  out  `mgr_obi_req_t`  shared request toward the crossbar.
- `rsp_i`  in  `mgr_obi_rsp_t`  shared response from the crossbar.
- `outst_o`  out  `$clog2(MaxOutst)+1`  current outstanding count.
- `err_o`  out  1  sticky; set when `rsp_i.rvalid` arrives while the FIFO is empty.

## Operation
- **Selection:** round-robin with a last-winner pointer `ptr`. Priority starts at `ptr+1` and wraps modulo `NumReq`. The winner is the first index with `req_i[k].req`.
- **Pointer update:** `ptr` updates to the winner only on a handshake (`req_o.req && rsp_i.gnt`).
- **Lock:** while `req_o.req` is high without `gnt`, the selection is held in `lock_q`/`sel_q`. The address, we, be, wdata and aid of `req_o` must not change until the grant, per the OBI rule. Newly arriving higher-priority requests do not preempt.
- **Request path:**
  - `req_o` = `req_i[sel]` with `req_o.req = req_i[sel].req && !full`.
  - `req_o.a.aid` is passed through unchanged.
- **Grant path:** `rsp_o[sel].gnt = rsp_i.gnt && !full && req_i[sel].req`. All other `rsp_o[k].gnt` = 0.
- **ID FIFO:**
  - Depth `MaxOutst`, width `$clog2(NumReq)`.
  - Push `sel` on handshake; pop on `rsp_i.rvalid`.
  - Read/write pointers wrap modulo `MaxOutst`; `full`/`empty` are derived from a count.
  - Push and pop in the same cycle leave the count unchanged.
- **Full:** `req_o.req` is forced to 0 even if `rsp_i.rvalid` pops in the same cycle. This keeps `rvalid` out of the request path.
- **Response routing:**
  - `rsp_o[k].r` = `rsp_i.r` for all k (broadcast).
  - `rsp_o[k].rvalid = rsp_i.rvalid && !empty && head == k`.
  - Responses are assumed in order, which the single crossbar port guarantees.
- **Error:** `rvalid` while empty is dropped (no `rsp_o` rvalid) and sets `err_o`. Only reset clears `err_o`.
- **Reset (asynchronous):**
  - Cleared state: `ptr = NumReq-1` (so index 0 wins first), `lock_q = 0`, FIFO empty, `outst_o = 0`, `err_o = 0`.
  - During reset, all `rsp_o` gnt/rvalid and `req_o.req` are 0.
  - Reset mid-transaction discards outstanding IDs. Late responses then flag `err_o`.

## Timing
- Request and grant paths are combinational: zero added latency, a single-cycle handshake.
- The response path is combinational from `rsp_i` through the FIFO head register.
- Registered state: `ptr`, `lock_q`, `sel_q`, FIFO storage/pointers/count, `err_o`.
- `outst_o` reflects the count register, updated on the edge after a handshake or response.
- Back-to-back grants to different requesters are allowed on consecutive cycles.
- Maximum sustained throughput is one transaction per cycle while the count is below `MaxOutst`.
- No combinational path from `rsp_i.rvalid` to `req_o.req` or to any `gnt`.

## Test plan
- **Reset value:** reset, then `req_i[0]` and `req_i[3]` high, `gnt` always 1 → grant order 0, 3, 0, 3…; `outst_o` tracks `rvalid` returned 1 cycle later.
- **Fairness:** all 5 requesting continuously, `gnt` = 1 → grant sequence 0, 1, 2, 3, 4, 0…; each index receives exactly 2 of 10 grants.
- **Lock:** `req_i[2]` at `addr 0x1000_0008` with `gnt` held 0 for 3 cycles while `req_i[0]` rises → `req_o.a.addr` stays `0x1000_0008` through all 4 cycles; index 2 is granted first.
- **Full:** `MaxOutst` = 4, 4 grants, `rvalid` withheld → `outst_o` = 4 and `req_o.req` = 0. One `rvalid` → `outst_o` = 3; the next grant occurs the following cycle.
- **Routing:** grants to 4, 1, 4 with `rdata` `0xA`, `0xB`, `0xC` → `rsp_o[4]` sees `0xA`, `rsp_o[1]` sees `0xB`, `rsp_o[4]` sees `0xC`; no rvalid reaches other indices.
- **Error and mid-operation reset:** 2 outstanding, assert `rst_i`, then `rvalid` pulse → no `rsp_o` rvalid, `err_o` = 1 and it stays 1 until the next reset.
